// File: rtl/instr_fetch_ctrl_if.sv
// Fetch-side bundle: start control, ROM address/data, the decode valid/ready
// stage, redirect request and status flags.
interface instr_fetch_ctrl_if #(
    parameter int ADDR_W  = 7,
    parameter int INSTR_W = 9
);
    logic               start;
    logic [ADDR_W-1:0]  rom_addr;
    logic [INSTR_W-1:0] rom_instr;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;
    logic               out_valid;
    logic               out_ready;
    logic               br_taken;
    logic [ADDR_W-1:0]  br_target;
    logic               busy;
    logic               done;

    // Fetch controller side
    modport master (
        input  start, rom_instr, out_ready, br_taken, br_target,
        output rom_addr, out_instr, out_pc, out_valid, busy, done
    );

    // Environment side (ROM, decode, execute, sequencer)
    modport slave (
        output start, rom_instr, out_ready, br_taken, br_target,
        input  rom_addr, out_instr, out_pc, out_valid, busy, done
    );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, reads the combinational ROM and
// issues words to decode through a single valid/ready register stage.
module instr_fetch_ctrl #(
    parameter int                   NUM_INSTR = 66,
    parameter int                   ADDR_W    = 7,
    parameter int                   INSTR_W   = 9,
    parameter logic [INSTR_W-1:0]   HALT_WORD = 9'h1FF
) (
    input  logic          clock,
    input  logic          reset_n,
    instr_fetch_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    localparam logic [ADDR_W:0] END_PC = (ADDR_W+1)'(NUM_INSTR);

    state_t             state, state_n;
    logic [ADDR_W-1:0]  pc, pc_n, opc, opc_n;
    logic [INSTR_W-1:0] oin, oin_n;
    logic               ov, ov_n;

    logic pc_ok, tgt_ok, free, accept, halt;

    assign pc_ok  = {1'b0, pc} < END_PC;
    assign tgt_ok = {1'b0, bus.br_target} < END_PC;
    assign free   = !ov || bus.out_ready;
    assign accept = ov && bus.out_ready;
    assign halt   = bus.rom_instr == HALT_WORD;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: if (bus.start) state_n = FETCH;
            FETCH: begin
                if (bus.br_taken)       state_n = tgt_ok ? FETCH : DRAIN;
                else if (!pc_ok)        state_n = DRAIN;
                else if (free && halt)  state_n = DRAIN;
            end
            DRAIN: begin
                if (bus.br_taken)       state_n = tgt_ok ? FETCH : DRAIN;
                else if (free)          state_n = DONE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        bus.busy = (state == FETCH) || (state == DRAIN);
        bus.done = (state == DONE);
    end

    // Datapath next values; a redirect always flushes the held word
    always_comb begin
        pc_n  = pc;
        opc_n = opc;
        oin_n = oin;
        ov_n  = ov;
        case (state)
            IDLE, DONE: if (bus.start) pc_n = '0;
            FETCH: begin
                if (bus.br_taken) begin
                    pc_n = bus.br_target;
                    ov_n = 1'b0;
                end else if (!pc_ok) begin
                    // Past the end: retire the last word if decode takes it
                    if (accept) ov_n = 1'b0;
                end else if (free) begin
                    oin_n = bus.rom_instr;
                    opc_n = pc;
                    ov_n  = 1'b1;
                    if (!halt) pc_n = pc + 1'b1;
                end
            end
            DRAIN: begin
                if (bus.br_taken) begin
                    pc_n = bus.br_target;
                    ov_n = 1'b0;
                end else if (accept) begin
                    ov_n = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc  <= '0;
            opc <= '0;
            oin <= '0;
            ov  <= 1'b0;
        end else begin
            pc  <= pc_n;
            opc <= opc_n;
            oin <= oin_n;
            ov  <= ov_n;
        end
    end

    assign bus.rom_addr  = pc;
    assign bus.out_pc    = opc;
    assign bus.out_instr = oin;
    assign bus.out_valid = ov;
endmodule
